// File: rtl/sort_n_floats_using_fsm_if.sv
// -----------------------------------------------------------------------------
// sort_n_floats_using_fsm_if
// Bundles the signals between sort_n_floats_using_fsm and its parent:
// the input/result handshake and the links to the external f_less_or_equal
// comparator.
//   master : parent side (drives valid_in/unsorted and the comparator results)
//   slave  : sorter side (drives valid_out/sorted/err/busy and the operands)
// Signals:
//   valid_in  - unsorted is valid; taken only while the sorter is idle or done
//   unsorted  - [0:N-1][FLEN-1:0] input elements
//   valid_out - one-cycle pulse, sorted/err are valid
//   sorted    - [0:N-1][FLEN-1:0] ascending result, held until the next accept
//   err       - sticky OR of f_le_err over the current sort
//   busy      - sort in progress, new input is dropped
//   f_le_a/b  - comparator operands
//   f_le_res  - comparator result a <= b (combinational)
//   f_le_err  - comparator error, NaN/Inf operand (combinational)
// -----------------------------------------------------------------------------
interface sort_n_floats_using_fsm_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned FLEN = 64
);
    logic                      valid_in;
    logic [0:N-1][FLEN-1:0]    unsorted;
    logic                      valid_out;
    logic [0:N-1][FLEN-1:0]    sorted;
    logic                      err;
    logic                      busy;
    logic [FLEN-1:0]           f_le_a;
    logic [FLEN-1:0]           f_le_b;
    logic                      f_le_res;
    logic                      f_le_err;

    modport master (
        output valid_in, unsorted, f_le_res, f_le_err,
        input  valid_out, sorted, err, busy, f_le_a, f_le_b
    );

    modport slave (
        input  valid_in, unsorted, f_le_res, f_le_err,
        output valid_out, sorted, err, busy, f_le_a, f_le_b
    );
endinterface

// File: rtl/sort_n_floats_using_fsm.sv
// -----------------------------------------------------------------------------
// sort_n_floats_using_fsm
// Sorts N IEEE-754 floats ascending (index 0 = smallest) with an in-place
// bubble sort, one compare per cycle through a shared external f_less_or_equal
// comparator. Equal elements are never swapped, so the sort is stable.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - sort_n_floats_using_fsm_if.slave (handshake, result, comparator)
// Parameters:
//   N     - element count, N >= 2
//   FLEN  - float width in bits
// Optional build macro:
//   SORT_EARLY_EXIT_EN - finish as soon as a full pass makes no swap.
//   Undefined: every sort runs exactly (N-1)^2 compares.
// -----------------------------------------------------------------------------
module sort_n_floats_using_fsm #(
    parameter int unsigned N    = 4,
    parameter int unsigned FLEN = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sort_n_floats_using_fsm_if.slave   bus
);

    localparam int unsigned     IW        = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N - 2);
    localparam logic [IW-1:0]   LAST_PASS = IW'(N - 2);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_e;

    typedef logic [0:N-1][FLEN-1:0] arr_t;

    state_e          state_q, state_d;
    arr_t            arr_q, arr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   pass_q, pass_d;
    logic            err_q, err_d;
    logic            valid_out_q, valid_out_d;

    logic [IW-1:0]   idx_nxt;
    logic            do_swap;
    logic            pass_end;
    logic            sort_end;

`ifdef SORT_EARLY_EXIT_EN
    logic            swapped_q, swapped_d;
    logic            swapped_pass;
`endif

    assign idx_nxt = idx_q + IW'(1);

    // idx is 0 outside SORT, so the operands fall back to arr[0]/arr[1].
    assign bus.f_le_a    = arr_q[idx_q];
    assign bus.f_le_b    = arr_q[idx_nxt];
    assign bus.sorted    = arr_q;
    assign bus.err       = err_q;
    assign bus.valid_out = valid_out_q;
    assign bus.busy      = (state_q == SORT);

    always_comb begin
        state_d  = state_q;
        arr_d    = arr_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        err_d    = err_q;
        do_swap  = 1'b0;
        pass_end = 1'b0;
        sort_end = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        swapped_d    = swapped_q;
        swapped_pass = 1'b0;
`endif

        case (state_q)
            SORT: begin
                // Swap follows f_le_res even when the comparator flags an error.
                do_swap = ~bus.f_le_res;
                if (do_swap) begin
                    arr_d[idx_q]   = arr_q[idx_nxt];
                    arr_d[idx_nxt] = arr_q[idx_q];
                end
                err_d    = err_q | bus.f_le_err;
                pass_end = (idx_q == LAST_IDX);
                sort_end = pass_end && (pass_q == LAST_PASS);
`ifdef SORT_EARLY_EXIT_EN
                // The flag restarts at idx=0 and folds in this cycle's swap, so
                // the last compare of a pass counts toward the exit decision.
                swapped_pass = ((idx_q == '0) ? 1'b0 : swapped_q) | do_swap;
                swapped_d    = swapped_pass;
                if (pass_end && !swapped_pass) begin
                    sort_end = 1'b1;
                end
`endif
                if (sort_end) begin
                    state_d = DONE;
                    idx_d   = '0;
                    pass_d  = '0;
                end else if (pass_end) begin
                    idx_d  = '0;
                    pass_d = pass_q + IW'(1);
                end else begin
                    idx_d = idx_nxt;
                end
            end

            default: begin
                // IDLE and DONE both accept; DONE with valid_in runs back-to-back.
                if (bus.valid_in) begin
                    arr_d   = bus.unsorted;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    pass_d  = '0;
                    state_d = SORT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        valid_out_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            arr_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            err_q       <= 1'b0;
            valid_out_q <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            arr_q       <= arr_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            valid_out_q <= valid_out_d;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q   <= swapped_d;
`endif
        end
    end

endmodule

// File: tb/tb_sort_n_floats_using_fsm.sv
// -----------------------------------------------------------------------------
// tb_sort_n_floats_using_fsm
// Bench for sort_n_floats_using_fsm (N=4, FLEN=64). Models the external
// f_less_or_equal comparator with real arithmetic and predicts results with a
// stable insertion sort, error flag and pass-count based latency.
// -----------------------------------------------------------------------------
module tb_sort_n_floats_using_fsm;

    localparam int unsigned N    = 4;
    localparam int unsigned FLEN = 64;
    localparam int          C    = (N - 1) * (N - 1);
`ifdef SORT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef logic [0:N-1][FLEN-1:0] vec_t;

    typedef struct {
        vec_t in;
        vec_t exp;
        bit   err;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort_n_floats_using_fsm_if #(.N(N), .FLEN(FLEN)) bus ();

    sort_n_floats_using_fsm #(.N(N), .FLEN(FLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic bit is_special(logic [63:0] x);
        return &x[62:52];
    endfunction

    // Behavioural f_less_or_equal.
    always_comb begin
        bus.f_le_err = is_special(bus.f_le_a) | is_special(bus.f_le_b);
        bus.f_le_res = ($bitstoreal(bus.f_le_a) <= $bitstoreal(bus.f_le_b));
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t ref_sort(vec_t v);
        vec_t r = v;
        for (int i = 1; i < int'(N); i++) begin
            logic [63:0] key = r[i];
            int j = i;
            while (j > 0 && $bitstoreal(r[j-1]) > $bitstoreal(key)) begin
                r[j] = r[j-1];
                j--;
            end
            r[j] = key;
        end
        return r;
    endfunction

    function automatic bit ref_err(vec_t v);
        bit e = 1'b0;
        for (int i = 0; i < int'(N); i++) e |= is_special(v[i]);
        return e;
    endfunction

    // Passes with swaps = max count of strictly-greater elements ahead of any
    // element; early exit adds one clean pass, capped at N-1.
    function automatic int ref_latency(vec_t v);
        int d = 0;
        int k;
        if (!EARLY) return C + 1;
        for (int i = 0; i < int'(N); i++) begin
            int cnt = 0;
            for (int j = 0; j < i; j++)
                if ($bitstoreal(v[j]) > $bitstoreal(v[i])) cnt++;
            if (cnt > d) d = cnt;
        end
        k = (d + 1 > int'(N) - 1) ? int'(N) - 1 : d + 1;
        return k * (int'(N) - 1) + 1;
    endfunction

    function automatic logic [63:0] r2b(real x);
        return $realtobits(x);
    endfunction

    task automatic run_sort(input vec_t v, input string tag, input bit chk_sorted,
                            input vec_t exp_sorted, input bit exp_err,
                            input bit chk_lat, input int exp_lat, input bit inject);
        int   first = 0;
        int   pulses = 0;
        bit   busy_bad = 1'b0;
        vec_t got = '0;
        logic got_err = 1'b0;
        @(negedge clk);
        bus.unsorted = v;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (inject && cyc == 3) begin
                bus.valid_in = 1'b1;
                bus.unsorted = {r2b(9.0), r2b(8.0), r2b(7.0), r2b(6.0)};
            end else if (inject && cyc == 4) begin
                bus.valid_in = 1'b0;
            end
            if (bus.valid_out) begin
                pulses++;
                if (first == 0) begin
                    first   = cyc;
                    got     = bus.sorted;
                    got_err = bus.err;
                end
            end
            if (chk_lat && cyc <= exp_lat && bus.busy !== (cyc < exp_lat)) busy_bad = 1'b1;
        end
        chk({tag, " pulses"}, 64'(pulses), 64'd1);
        if (chk_lat) begin
            chk({tag, " latency"}, 64'(first), 64'(exp_lat));
            chk({tag, " busy"}, 64'(busy_bad), 64'd0);
        end
        chk({tag, " err"}, 64'(got_err), 64'(exp_err));
        if (chk_sorted)
            for (int i = 0; i < int'(N); i++)
                chk($sformatf("%s sorted[%0d]", tag, i), got[i], exp_sorted[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_rec_t tbl[4];
        vec_t a, b, rv;
        int cyc;
        int pulses;

        tbl[0].in  = {r2b(4.0), r2b(3.0), r2b(2.0), r2b(1.0)};
        tbl[0].exp = {r2b(1.0), r2b(2.0), r2b(3.0), r2b(4.0)};
        tbl[0].err = 1'b0;
        tbl[1].in  = {r2b(1.0), r2b(2.0), r2b(3.0), r2b(4.0)};
        tbl[1].exp = {r2b(1.0), r2b(2.0), r2b(3.0), r2b(4.0)};
        tbl[1].err = 1'b0;
        tbl[2].in  = {64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, r2b(-1.5), r2b(5.6e5)};
        tbl[2].exp = {r2b(-1.5), 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, r2b(5.6e5)};
        tbl[2].err = 1'b0;
        tbl[3].in  = {r2b(1.0), 64'h7FF1_2345_6789_ABCD, r2b(2.0), 64'hFFF0_0000_0000_0000};
        tbl[3].exp = '0;
        tbl[3].err = 1'b1;

        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.unsorted = '0;
        #1;
        chk("reset valid_out", 64'(bus.valid_out), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset err", 64'(bus.err), 64'd0);
        chk("reset sorted", 64'(|bus.sorted), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fixed vectors.
        for (int t = 0; t < 4; t++) begin
            run_sort(tbl[t].in, $sformatf("tbl%0d", t), !tbl[t].err, tbl[t].exp, tbl[t].err,
                     !(tbl[t].err && EARLY), tbl[t].err ? C + 1 : ref_latency(tbl[t].in), 1'b0);
        end

        // Second valid_in during SORT is dropped.
        run_sort(tbl[0].in, "inject", 1'b1, tbl[0].exp, 1'b0, 1'b1, ref_latency(tbl[0].in), 1'b1);

        // Reset in cycle 5 of a sort.
        @(negedge clk);
        bus.unsorted = tbl[0].in;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst valid_out", 64'(bus.valid_out), 64'd0);
        chk("midrst busy", 64'(bus.busy), 64'd0);
        chk("midrst err", 64'(bus.err), 64'd0);
        chk("midrst sorted", 64'(|bus.sorted), 64'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
        chk("midrst no pulse", 64'(pulses), 64'd0);
        b = {r2b(2.0), r2b(1.0), r2b(3.0), r2b(0.5)};
        run_sort(b, "postrst", 1'b1, {r2b(0.5), r2b(1.0), r2b(2.0), r2b(3.0)}, 1'b0,
                 1'b1, ref_latency(b), 1'b0);

        // Back-to-back: new valid_in on the DONE cycle.
        a = tbl[0].in;
        @(negedge clk);
        bus.unsorted = a;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        cyc = 1;
        while (!bus.valid_out && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b first latency", 64'(cyc), 64'(ref_latency(a)));
        chk("b2b first sorted[0]", bus.sorted[0], r2b(1.0));
        chk("b2b first sorted[3]", bus.sorted[3], r2b(4.0));
        bus.unsorted = b;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        cyc = 1;
        chk("b2b busy", 64'(bus.busy), 64'd1);
        while (!bus.valid_out && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b second latency", 64'(cyc), 64'(ref_latency(b)));
        rv = ref_sort(b);
        for (int i = 0; i < int'(N); i++)
            chk($sformatf("b2b second sorted[%0d]", i), bus.sorted[i], rv[i]);

        // Randomized finite inputs, small value range so duplicates occur.
        for (int it = 0; it < 24; it++) begin
            vec_t v;
            for (int i = 0; i < int'(N); i++)
                v[i] = r2b((real'($urandom_range(0, 15)) - 7.0) * 0.5);
            run_sort(v, $sformatf("rand%0d", it), 1'b1, ref_sort(v), ref_err(v),
                     1'b1, ref_latency(v), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
